mmp_iddmm_subfinal: RTL
=======================

# mmp_iddmm_subfinal

Word-serial final conditional subtractor for the 4096-bit IDDMM datapath. It consumes the raw Montgomery result T (WORDS × 256-bit words plus one overflow bit) and the modulus M, least-significant word first. It computes T − M with a registered borrow chain and buffers both T and T − M. It then streams out the reduced result: T − M if T ≥ M, otherwise T. It sits directly after the IDDMM accumulation datapath and is the inverse-direction counterpart of the 256+128+1 add stage (difference and borrow instead of sum and carry).

## Interface
- WORDS, 16, number of 256-bit words per operand (4096/256); legal range 2..64
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input word valid
- in_ready  output  1  block accepts an input word
- in_a  input  256  current word of T, LS word first
- in_b  input  256  current word of M, same index as in_a
- in_a_top  input  1  bit 4096 of T; sampled only with the WORDS-th input word
- out_valid  output  1  output word valid
- out_ready  input  1  downstream accepts output word
- out_d  output  256  current word of the reduced result, LS word first
- out_last  output  1  high with the WORDS-th output word
- out_sub  output  1  1 = T − M selected; stable for the whole output burst
- busy  output  1  high from the first accepted input word until the last output handshake

## Operation
- States: ST_IN (collect), ST_OUT (emit). Word index counter idx, 0..WORDS−1, is shared and cleared on each state entry.
- ST_IN: on in_valid & in_ready, perform the following, then increment idx.
  - Compute the 257-bit {bw_n, diff} = {1'b0, in_a} − {1'b0, in_b} − borrow, where bw_n = 1 when the result is negative.
  - Store in_a in buf_t[idx] and diff in buf_d[idx]; borrow <= bw_n.
- borrow is cleared to 0 on entry to ST_IN, so each operation starts borrow-free.
- When word WORDS−1 is accepted:
  - sel = in_a_top | ~bw_n. Subtraction is kept when T has its overflow bit set or when no final borrow occurs.
  - Latch out_sub = sel and go to ST_OUT.
- ST_OUT:
  - out_d = sel ? buf_d[idx] : buf_t[idx]; out_last = (idx == WORDS−1).
  - idx advances on out_valid & out_ready.
  - After the last-word handshake, go to ST_IN.
- The result width is exactly 4096 bits. Bit 4096 of T − M is discarded: it is zero by construction, since T < 2M.
- in_valid is ignored in ST_OUT (in_ready = 0). out_ready is ignored in ST_IN (out_valid = 0).
- Buffers may map to two WORDS×256 RAMs. Read data must be presented with out_valid, with no bubble between back-to-back output words when out_ready is held high.

## Timing
- Reset values:
  - in_ready = 0, out_valid = 0, out_d = 0, out_last = 0, out_sub = 0, busy = 0.
  - State ST_IN, idx = 0, borrow = 0.
- in_ready rises on the first clock edge after rst_n deasserts.
- Input: one word per cycle max. The full input phase takes WORDS handshakes.
- Output start: out_valid asserts on the cycle after the WORDS-th input handshake (1 cycle latency). Adding the pipeline stage below makes this 2 cycles.
- Backpressure: while out_valid & ~out_ready, out_d, out_last and out_sub hold stable.
- Turnaround: in_ready = 1 on the cycle after the final output handshake, so there is no overlap between operations.
- Reset mid-operation aborts immediately. All outputs return to reset values and buffered data is discarded; no partial result is emitted.
- Equality T = M: borrow = 0, so sel = 1 and the output is all-zero with out_sub = 1.

## Configuration
- MMP_IDDMM_SUBFINAL_PIPE_EN defined:
  - The 257-bit word subtraction is split into two 128-bit halves with a registered mid-borrow (one extra pipeline stage).
  - The write into buf_d and the sel decision occur one cycle later.
  - Output start latency becomes 2 cycles.
  - Input throughput stays at one word per cycle.
- Undefined: single-cycle 257-bit subtraction, output start latency 1 cycle.
- Functional results are identical in both builds.

## Test plan
- T = 5, M = 3 (upper words 0, in_a_top = 0), continuous valid/ready -> out word0 = 2, words 1..15 = 0, out_sub = 1, out_valid one cycle after 16th input.
- T = 3, M = 5 -> out word0 = 3, others 0, out_sub = 0.
- T = M = random 4096-bit -> all output words 0, out_sub = 1.
- in_a_top = 1, T low words all 0, M = 1 -> every output word = 256'hFFFF…FFFF, out_sub = 1; borrow propagates through all 16 words.
- Random T < 2M, out_ready toggled pseudo-randomly, in_valid with gaps -> output matches reference (T ≥ M ? T − M : T); out_d holds under stall; out_last only on word 15.
- rst_n pulsed low after 8 input words -> outputs at reset values. The next full operation (T = 5, M = 3) then yields word0 = 2 and no stale data.

Source files
------------

// File: rtl/mmp_iddmm_subfinal.sv
// Word-serial final conditional subtractor: streams T - M when T >= M (or T has its overflow bit), else T.
// Define MMP_IDDMM_SUBFINAL_PIPE_EN to split each word subtraction into two registered 128-bit halves.
module mmp_iddmm_subfinal #(
  parameter int WORDS = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] in_a,
  input  logic [255:0] in_b,
  input  logic         in_a_top,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_d,
  output logic         out_last,
  output logic         out_sub,
  output logic         busy
);
  localparam int DATA_W = 256;
  localparam int HALF_W = DATA_W / 2;
  localparam int IDX_W  = $clog2(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic {ST_IN = 1'b0, ST_OUT = 1'b1} state_t;

  state_t             st_q, st_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               borrow_q, borrow_d;
  logic               busy_q, busy_d;
  logic               out_sub_q, out_sub_d;
  logic [DATA_W-1:0]  out_d_q, out_d_d;
  logic               init_q;

  logic [DATA_W-1:0]  buf_t [WORDS];
  logic [DATA_W-1:0]  buf_d [WORDS];

  logic               in_hs, out_hs;
  logic               s_vld, s_last, s_top, s_bw;
  logic [IDX_W-1:0]   s_idx;
  logic [DATA_W-1:0]  s_a, s_diff;
  logic               stall_in;
  logic               fin, sel;

  assign in_hs  = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;

`ifdef MMP_IDDMM_SUBFINAL_PIPE_EN
  // Stage p0: low half for both possible incoming borrows, so stage p1 only muxes then subtracts the high half
  logic [HALF_W:0]    lo0_p0, lo1_p0;
  logic               vld_p1, last_p1, top_p1, bl0_p1, bl1_p1;
  logic [IDX_W-1:0]   idx_p1;
  logic [DATA_W-1:0]  a_p1;
  logic [HALF_W-1:0]  b_hi_p1, lo0_p1, lo1_p1;
  logic               bl_p1;
  logic [HALF_W-1:0]  lo_p1;
  logic [HALF_W:0]    hi_p1;

  assign lo0_p0 = {1'b0, in_a[HALF_W-1:0]} - {1'b0, in_b[HALF_W-1:0]};
  assign lo1_p0 = {1'b0, in_a[HALF_W-1:0]} - {1'b0, in_b[HALF_W-1:0]} - {{HALF_W{1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= in_hs;
  end

  always_ff @(posedge clk) begin
    if (in_hs) begin
      idx_p1  <= idx_q;
      last_p1 <= (idx_q == LAST_IDX);
      top_p1  <= in_a_top;
      a_p1    <= in_a;
      b_hi_p1 <= in_b[DATA_W-1:HALF_W];
      lo0_p1  <= lo0_p0[HALF_W-1:0];
      lo1_p1  <= lo1_p0[HALF_W-1:0];
      bl0_p1  <= lo0_p0[HALF_W];
      bl1_p1  <= lo1_p0[HALF_W];
    end
  end

  // Stage p1: resolve the low half with the previous word's registered borrow, then the high half
  always_comb begin
    bl_p1 = borrow_q ? bl1_p1 : bl0_p1;
    lo_p1 = borrow_q ? lo1_p1 : lo0_p1;
    hi_p1 = {1'b0, a_p1[DATA_W-1:HALF_W]} - {1'b0, b_hi_p1} - {{HALF_W{1'b0}}, bl_p1};
  end

  assign s_vld    = vld_p1;
  assign s_idx    = idx_p1;
  assign s_last   = last_p1;
  assign s_top    = top_p1;
  assign s_a      = a_p1;
  assign s_diff   = {hi_p1[HALF_W-1:0], lo_p1};
  assign s_bw     = hi_p1[HALF_W];
  assign stall_in = vld_p1 & last_p1;
`else
  logic [DATA_W:0] full_p0;

  assign full_p0  = {1'b0, in_a} - {1'b0, in_b} - {{DATA_W{1'b0}}, borrow_q};
  assign s_vld    = in_hs;
  assign s_idx    = idx_q;
  assign s_last   = (idx_q == LAST_IDX);
  assign s_top    = in_a_top;
  assign s_a      = in_a;
  assign s_diff   = full_p0[DATA_W-1:0];
  assign s_bw     = full_p0[DATA_W];
  assign stall_in = 1'b0;
`endif

  assign fin = s_vld & s_last;
  assign sel = s_top | ~s_bw;

  always_ff @(posedge clk) begin
    if (s_vld) begin
      buf_t[s_idx] <= s_a;
      buf_d[s_idx] <= s_diff;
    end
  end

  // Output word is registered; the next word is fetched on each handshake so bursts have no bubbles
  always_comb begin
    st_d      = st_q;
    idx_d     = idx_q;
    borrow_d  = borrow_q;
    busy_d    = busy_q;
    out_sub_d = out_sub_q;
    out_d_d   = out_d_q;
    if (st_q == ST_IN) begin
      if (in_hs) begin
        busy_d = 1'b1;
        idx_d  = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      end
      if (s_vld) borrow_d = s_bw;
      if (fin) begin
        st_d      = ST_OUT;
        idx_d     = '0;
        out_sub_d = sel;
        out_d_d   = sel ? buf_d[0] : buf_t[0];
      end
    end else if (out_hs) begin
      if (idx_q == LAST_IDX) begin
        st_d     = ST_IN;
        idx_d    = '0;
        borrow_d = 1'b0;
        busy_d   = 1'b0;
      end else begin
        idx_d   = idx_q + 1'b1;
        out_d_d = out_sub_q ? buf_d[idx_q + 1'b1] : buf_t[idx_q + 1'b1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= ST_IN;
      idx_q     <= '0;
      borrow_q  <= 1'b0;
      busy_q    <= 1'b0;
      out_sub_q <= 1'b0;
      out_d_q   <= '0;
      init_q    <= 1'b0;
    end else begin
      st_q      <= st_d;
      idx_q     <= idx_d;
      borrow_q  <= borrow_d;
      busy_q    <= busy_d;
      out_sub_q <= out_sub_d;
      out_d_q   <= out_d_d;
      init_q    <= 1'b1;
    end
  end

  assign in_ready  = init_q & (st_q == ST_IN) & ~stall_in;
  assign out_valid = (st_q == ST_OUT);
  assign out_last  = (st_q == ST_OUT) & (idx_q == LAST_IDX);
  assign out_d     = out_d_q;
  assign out_sub   = out_sub_q;
  assign busy      = busy_q;

endmodule
